alarm_ctrl: RTL and testbench



---
 rtl/alarm_ctrl_pkg.sv | 21 ++
 rtl/alarm_ctrl_bcd_wrap_inc.sv | 31 +++
 rtl/alarm_ctrl.sv | 155 +++++++++++++++
 tb/tb_alarm_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the alarm controller: FSM state type, BCD digit
// width, the wrap limits of the alarm hour/minute registers and the width of
// the shared seconds counter.
package alarm_ctrl_pkg;

  localparam int BCD_W = 4;

  // Largest value each 2-digit BCD field may hold before wrapping to 00.
  localparam logic [2*BCD_W-1:0] MAX_HOUR_BCD = 8'h23;
  localparam logic [2*BCD_W-1:0] MAX_MIN_BCD  = 8'h59;

  // Seconds counter used for both the ring timeout and the snooze interval.
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } alm_state_e;

endpackage

// File: rtl/alarm_ctrl_bcd_wrap_inc.sv
// bcd_wrap_inc: combinational 2-digit BCD increment that wraps to 00 after
// MAX_BCD.
//   val  in  8  current BCD value {tens, ones}
//   nxt  out 8  val + 1 in BCD, or 00 when val == MAX_BCD
module bcd_wrap_inc
  import alarm_ctrl_pkg::*;
#(
  parameter logic [2*BCD_W-1:0] MAX_BCD = 8'h59
) (
  input  logic [2*BCD_W-1:0] val,
  output logic [2*BCD_W-1:0] nxt
);

  logic [BCD_W-1:0] tens;
  logic [BCD_W-1:0] ones;

  assign tens = val[2*BCD_W-1:BCD_W];
  assign ones = val[BCD_W-1:0];

  always_comb begin
    nxt = '0;
    if (val == MAX_BCD) begin
      nxt = '0;
    end else if (ones == BCD_W'(9)) begin
      nxt = {tens + BCD_W'(1), {BCD_W{1'b0}}};
    end else begin
      nxt = {tens, ones + BCD_W'(1)};
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm-clock alarm register and ring/snooze controller.
//   clk        in   1   mains tick clock, single domain
//   rst_n      in   1   asynchronous active-low reset
//   time_bcd   in  24   current time {Ht,Ho,Mt,Mo,St,So}, 24h BCD
//   sec_pulse  in   1   one-cycle 1 Hz strobe
//   alm_set    in   1   alarm-set mode (level)
//   inc_h      in   1   alarm hour +1 (pulse)
//   inc_m      in   1   alarm minute +1 (pulse)
//   alm_en     in   1   alarm armed (level)
//   snooze     in   1   snooze request (pulse)
//   stop       in   1   stop request (pulse)
//   buzz       out  1   registered buzzer drive, beats at 1/2 Hz while ringing
//   ringing    out  1   state is RINGING
//   snoozing   out  1   state is SNOOZE
//   alm_bcd    out 16   alarm time {Ht,Ho,Mt,Mo}
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 540,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] time_bcd,
  input  logic        sec_pulse,
  input  logic        alm_set,
  input  logic        inc_h,
  input  logic        inc_m,
  input  logic        alm_en,
  input  logic        snooze,
  input  logic        stop,
  output logic        buzz,
  output logic        ringing,
  output logic        snoozing,
  output logic [15:0] alm_bcd
);

  localparam int SNZ_W = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

  alm_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SNZ_W-1:0] snz_q, snz_d;
  logic             beat_q, beat_d;
  logic             buzz_q;
  logic [7:0]       alm_h_q, alm_m_q;
  logic [7:0]       alm_h_inc, alm_m_inc;
  logic             alm_match;
  logic             ring_done;
  logic             snz_done;

  bcd_wrap_inc #(.MAX_BCD(MAX_HOUR_BCD)) u_hour_inc (
    .val (alm_h_q),
    .nxt (alm_h_inc)
  );

  bcd_wrap_inc #(.MAX_BCD(MAX_MIN_BCD)) u_min_inc (
    .val (alm_m_q),
    .nxt (alm_m_inc)
  );

  // Only the :00 second of the matching minute triggers, so a stopped alarm
  // cannot re-fire later in the same minute.
  assign alm_match = (time_bcd[23:8] == {alm_h_q, alm_m_q}) && (time_bcd[7:0] == 8'h00);
  assign ring_done = sec_pulse && (cnt_q == CNT_W'(RING_SECS - 1));
  assign snz_done  = sec_pulse && (cnt_q == CNT_W'(SNOOZE_SECS - 1));

  // Next state: disarm beats stop beats snooze beats timeout.
  always_comb begin
    state_d = state_q;
    snz_d   = snz_q;
    if (!alm_en) begin
      state_d = ST_IDLE;
      snz_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!alm_set && sec_pulse && alm_match) state_d = ST_RINGING;
        end
        ST_RINGING: begin
          if (stop) begin
            state_d = ST_IDLE;
            snz_d   = '0;
          end else if (snooze && (snz_q < SNZ_W'(MAX_SNOOZE))) begin
            state_d = ST_SNOOZE;
            snz_d   = snz_q + SNZ_W'(1);
          end else if (ring_done) begin
            state_d = ST_IDLE;
            snz_d   = '0;
          end
        end
        ST_SNOOZE: begin
          if (stop) begin
            state_d = ST_IDLE;
            snz_d   = '0;
          end else if (snz_done) begin
            state_d = ST_RINGING;
          end
        end
        default: begin
          state_d = ST_IDLE;
          snz_d   = '0;
        end
      endcase
    end
  end

  // Seconds counter restarts on every state change; beat starts high on
  // RINGING entry so the buzzer sounds immediately.
  always_comb begin
    cnt_d  = cnt_q;
    beat_d = beat_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (sec_pulse && (state_q != ST_IDLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (state_d != ST_RINGING) begin
      beat_d = 1'b0;
    end else if (state_q != ST_RINGING) begin
      beat_d = 1'b1;
    end else if (sec_pulse) begin
      beat_d = ~beat_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      snz_q   <= '0;
      beat_q  <= 1'b0;
      buzz_q  <= 1'b0;
      alm_h_q <= 8'h00;
      alm_m_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snz_q   <= snz_d;
      beat_q  <= beat_d;
      buzz_q  <= (state_d == ST_RINGING) && beat_d;
      if (alm_set && (state_q == ST_IDLE)) begin
        if (inc_h) alm_h_q <= alm_h_inc;
        if (inc_m) alm_m_q <= alm_m_inc;
      end
    end
  end

  assign buzz     = buzz_q;
  assign ringing  = (state_q == ST_RINGING);
  assign snoozing = (state_q == ST_SNOOZE);
  assign alm_bcd  = {alm_h_q, alm_m_q};

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios plus a randomized
// phase, compared against a behavioural model of the alarm clock.
module tb_alarm_ctrl;

  localparam int RING   = 60;
  localparam int SNZ    = 540;
  localparam int MAXS   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] time_bcd;
  logic        sec_pulse, alm_set, inc_h, inc_m, alm_en, snooze, stop;
  logic        buzz, ringing, snoozing;
  logic [15:0] alm_bcd;

  always #5 clk = ~clk;

  alarm_ctrl #(
    .RING_SECS   (RING),
    .SNOOZE_SECS (SNZ),
    .MAX_SNOOZE  (MAXS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .time_bcd  (time_bcd),
    .sec_pulse (sec_pulse),
    .alm_set   (alm_set),
    .inc_h     (inc_h),
    .inc_m     (inc_m),
    .alm_en    (alm_en),
    .snooze    (snooze),
    .stop      (stop),
    .buzz      (buzz),
    .ringing   (ringing),
    .snoozing  (snoozing),
    .alm_bcd   (alm_bcd)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: what the alarm clock is doing, in plain terms.
  bit m_ring, m_snz;
  int m_secs;   // seconds strobes seen since the current ring/snooze period began
  int m_used;   // snoozes used for this alarm event
  int m_ah, m_am;
  int tsec;     // wall-clock seconds since midnight driven on time_bcd

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] tbcd(input int s);
    int w;
    w = ((s % 86400) + 86400) % 86400;
    return {bcd2(w / 3600), bcd2((w / 60) % 60), bcd2(w % 60)};
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ringing"},  24'(ringing),  24'(m_ring));
    check({tag, ".snoozing"}, 24'(snoozing), 24'(m_snz));
    check({tag, ".buzz"},     24'(buzz),     24'(m_ring && (m_secs % 2 == 0)));
    check({tag, ".alm_bcd"},  24'(alm_bcd),  24'({bcd2(m_ah), bcd2(m_am)}));
  endtask

  task automatic model_reset();
    m_ring = 0; m_snz = 0; m_secs = 0; m_used = 0; m_ah = 0; m_am = 0;
  endtask

  // Apply one clock edge worth of behaviour using the inputs currently driven.
  task automatic model_edge();
    bit idle;
    idle = !m_ring && !m_snz;
    if (idle && alm_set) begin
      if (inc_h) m_ah = (m_ah + 1) % 24;
      if (inc_m) m_am = (m_am + 1) % 60;
    end
    if (!alm_en) begin
      m_ring = 0; m_snz = 0; m_used = 0;
    end else if (!idle && stop) begin
      m_ring = 0; m_snz = 0; m_used = 0;
    end else if (m_ring && snooze && m_used < MAXS) begin
      m_ring = 0; m_snz = 1; m_used++; m_secs = 0;
    end else if (m_ring && sec_pulse) begin
      if (m_secs + 1 == RING) begin
        m_ring = 0; m_used = 0;
      end else m_secs++;
    end else if (m_snz && sec_pulse) begin
      if (m_secs + 1 == SNZ) begin
        m_snz = 0; m_ring = 1; m_secs = 0;
      end else m_secs++;
    end else if (idle && !alm_set && sec_pulse &&
                 time_bcd == {bcd2(m_ah), bcd2(m_am), 8'h00}) begin
      m_ring = 1; m_secs = 0;
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
    sec_pulse = 0; inc_h = 0; inc_m = 0; snooze = 0; stop = 0;
  endtask

  task automatic sec_tick(input string tag);
    tsec++;
    time_bcd  = tbcd(tsec);
    sec_pulse = 1;
    step(tag);
  endtask

  // Move the wall clock to one second before the alarm and strobe into :00.
  task automatic trigger(input string tag);
    tsec = m_ah * 3600 + m_am * 60 - 1;
    sec_tick(tag);
  endtask

  initial begin
    rst_n = 0; time_bcd = 24'h000000; sec_pulse = 0; alm_set = 0;
    inc_h = 0; inc_m = 0; alm_en = 0; snooze = 0; stop = 0; tsec = 0;
    model_reset();
    #2;
    check("rst.ringing",  24'(ringing),  24'h0);
    check("rst.snoozing", 24'(snoozing), 24'h0);
    check("rst.buzz",     24'(buzz),     24'h0);
    check("rst.alm_bcd",  24'(alm_bcd),  24'h0);
    @(negedge clk);
    rst_n = 1;

    // Alarm register: count up to 23:59, then both wrap together.
    alm_set = 1;
    repeat (23) begin inc_h = 1; step("set_h"); end
    repeat (59) begin inc_m = 1; step("set_m"); end
    check("set_2359", 24'(alm_bcd), 24'h002359);
    inc_h = 1; inc_m = 1; step("wrap");
    check("wrap_0000", 24'(alm_bcd), 24'h000000);

    // Set 06:30 and arm.
    repeat (6)  begin inc_h = 1; step("set_h"); end
    repeat (30) begin inc_m = 1; step("set_m"); end
    check("set_0630", 24'(alm_bcd), 24'h000630);
    alm_set = 0; alm_en = 1;
    step("armed");

    // Trigger at 06:30:00 and let it ring out; inc pulses must be ignored.
    trigger("trig");
    check("trig.ringing", 24'(ringing), 24'h1);
    check("trig.buzz",    24'(buzz),    24'h1);
    for (int i = 0; i < RING; i++) begin
      repeat ($urandom_range(0, 2)) begin
        inc_h = 1'($urandom); inc_m = 1'($urandom); step("ring_gap");
      end
      sec_tick("ring_tick");
      if (i == 0) check("ring.buzz_toggle", 24'(buzz), 24'h0);
    end
    check("autostop.ringing", 24'(ringing), 24'h0);
    check("autostop.alm_bcd", 24'(alm_bcd), 24'h000630);

    // Three snoozes, each returning to ringing after the interval; the fourth is ignored.
    trigger("trig2");
    for (int s = 0; s < MAXS; s++) begin
      repeat ($urandom_range(0, 3)) sec_tick("pre_snz");
      snooze = 1; step("snooze");
      check("snz.snoozing", 24'(snoozing), 24'h1);
      check("snz.buzz",     24'(buzz),     24'h0);
      for (int i = 0; i < SNZ; i++) begin
        if ($urandom_range(0, 19) == 0) snooze = 1;
        sec_tick("snz_tick");
      end
      check("snz_end.ringing", 24'(ringing), 24'h1);
    end
    snooze = 1; step("snooze4");
    check("snooze4.ringing",  24'(ringing),  24'h1);
    check("snooze4.snoozing", 24'(snoozing), 24'h0);

    // Stop wins over snooze in the same cycle and clears the snooze count.
    stop = 1; snooze = 1; step("stop_snz");
    check("stop_snz.ringing",  24'(ringing),  24'h0);
    check("stop_snz.snoozing", 24'(snoozing), 24'h0);
    trigger("trig3");
    snooze = 1; step("snz_after_clear");
    check("cleared.snoozing", 24'(snoozing), 24'h1);
    stop = 1; step("stop_in_snz");
    repeat (10) sec_tick("no_retrig");
    check("no_retrig.ringing", 24'(ringing), 24'h0);
    stop = 1; step("stop_idle");

    // Disarm while ringing, then asynchronous reset mid-snooze.
    trigger("trig4");
    alm_en = 0; step("disarm");
    check("disarm.ringing", 24'(ringing), 24'h0);
    alm_en = 1;
    trigger("trig5");
    snooze = 1; step("snz5");
    #3;
    rst_n = 0;
    #1;
    model_reset();
    check("arst.ringing",  24'(ringing),  24'h0);
    check("arst.snoozing", 24'(snoozing), 24'h0);
    check("arst.buzz",     24'(buzz),     24'h0);
    check("arst.alm_bcd",  24'(alm_bcd),  24'h0);
    @(negedge clk);
    rst_n = 1;
    repeat (5) sec_tick("post_rst");
    check("post_rst.ringing", 24'(ringing), 24'h0);

    // Randomized traffic around a random alarm time.
    for (int i = 0; i < 3000; i++) begin
      alm_en  = ($urandom_range(0, 39) != 0);
      alm_set = ($urandom_range(0, 9) == 0);
      inc_h   = ($urandom_range(0, 5) == 0);
      inc_m   = ($urandom_range(0, 3) == 0);
      snooze  = ($urandom_range(0, 15) == 0);
      stop    = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 10) == 0) tsec = m_ah * 3600 + m_am * 60 - 1;
        tsec++;
        time_bcd  = tbcd(tsec);
        sec_pulse = 1;
      end
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
